aes_mode_engine: RTL and testbench

AES_MODE_ENGINE -- requirements
Module: aes_mode_engine

---
 rtl/aes_mode_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_mode_engine.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB/CBC/CTR block-mode wrapper around an external AES-128 core.
// Collects 128/DW input beats into a block, hands it to the core, applies the
// mode's chaining rule to the result and streams it back out MSB-first.
module aes_mode_engine #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] nblocks_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     iv_i,
    input  logic [DW-1:0]    a_data_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    output logic [DW-1:0]    d_data_o,
    output logic [DW/8-1:0]  d_strb_o,
    output logic             d_valid_o,
    input  logic             d_ready_i,
    output logic             core_ld_o,
    output logic [127:0]     core_key_o,
    output logic [127:0]     core_text_o,
    input  logic             core_done_i,
    input  logic [127:0]     core_text_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    localparam int unsigned BEATS = 128 / DW;
    localparam int unsigned BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] MODE_CBC = 2'd1;
    localparam logic [1:0] MODE_CTR = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64 || DW == 128)) begin : g_dw_check
        $error("aes_mode_engine: illegal DW %0d", DW);
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CIPH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       mode_q;
    logic [127:0]     key_q;
    logic [CNT_W-1:0] nblk_q;
    logic [127:0]     chain_q;
    logic [127:0]     p_q;
    logic [127:0]     out_q;
    logic [127:0]     text_q;
    logic [BI_W-1:0]  beat_q;
    logic [CNT_W-1:0] blk_q;
    logic             ld_issued_q;
    logic             got_res_q;
    logic             done_q;
    logic             err_q;

    logic             a_hs, d_hs, last_beat, res_take, flush_need;
    logic [CNT_W-1:0] blk_inc;
    logic             start_go, zero_done, mode_err, job_done;
    logic [127:0]     p_next, text_next, res_out, chain_upd;
    logic [DW-1:0]    d_sel;

    // Handshakes and core-result acceptance; clear discards anything in flight.
    assign a_ready_o  = (state_q == ST_LOAD) && enable_i;
    assign d_valid_o  = (state_q == ST_DRAIN) && enable_i;
    assign core_ld_o  = (state_q == ST_CIPH) && enable_i && !ld_issued_q && !clear_i;
    assign a_hs       = a_ready_o && a_valid_i && !clear_i;
    assign d_hs       = d_valid_o && d_ready_i && !clear_i;
    assign last_beat  = (beat_q == BI_W'(BEATS - 1));
    assign blk_inc    = blk_q + CNT_W'(1);
    assign res_take   = (state_q == ST_CIPH) && ld_issued_q && !got_res_q && core_done_i && !clear_i;
    assign flush_need = ld_issued_q && !got_res_q && !core_done_i;

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign blk_cnt_o   = blk_q;
    assign core_key_o  = key_q;
    assign core_text_o = text_q;
    assign d_strb_o    = {(DW/8){state_q == ST_DRAIN}};
    assign d_data_o    = (state_q == ST_DRAIN) ? d_sel : '0;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin : fsm_reg
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and one-cycle control strobes.
    always_comb begin : fsm_next
        state_d   = state_q;
        start_go  = 1'b0;
        zero_done = 1'b0;
        mode_err  = 1'b0;
        job_done  = 1'b0;
        if (clear_i) begin
            // A block already issued to the core must be drained from it first.
            state_d = (state_q == ST_CIPH && flush_need) ? ST_FLUSH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && enable_i) begin
                        if (mode_i == MODE_RSV)       mode_err  = 1'b1;
                        else if (nblocks_i == '0)     zero_done = 1'b1;
                        else begin
                            start_go = 1'b1;
                            state_d  = ST_LOAD;
                        end
                    end
                end
                ST_LOAD:  if (a_hs && last_beat) state_d = ST_CIPH;
                ST_CIPH:  if (enable_i && (got_res_q || res_take)) state_d = ST_DRAIN;
                ST_DRAIN: begin
                    if (d_hs && last_beat) begin
                        if (blk_inc == nblk_q) begin
                            state_d  = ST_IDLE;
                            job_done = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_FLUSH: if (enable_i && (got_res_q || core_done_i)) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Block assembly, core input selection and mode post-processing.
    always_comb begin : datapath_comb
        p_next = p_q;
        d_sel  = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == BI_W'(k)) begin
                p_next[127 - k*DW -: DW] = a_data_i;
                d_sel                    = out_q[127 - k*DW -: DW];
            end
        end
        case (mode_q)
            MODE_CBC: begin
                text_next = p_next ^ chain_q;
                res_out   = core_text_i;
                chain_upd = core_text_i;
            end
            MODE_CTR: begin
                text_next = chain_q;
                res_out   = core_text_i ^ p_q;
                chain_upd = {chain_q[127:32], chain_q[31:0] + 32'd1};
            end
            default: begin
                text_next = p_next;
                res_out   = core_text_i;
                chain_upd = chain_q;
            end
        endcase
    end

    // Job parameters and chain register; chain is reloaded from iv on every start.
    always_ff @(posedge clk_i or negedge rst_ni) begin : job_regs
        if (!rst_ni) begin
            mode_q  <= '0;
            key_q   <= '0;
            nblk_q  <= '0;
            chain_q <= '0;
        end else if (start_go) begin
            mode_q  <= mode_i;
            key_q   <= key_i;
            nblk_q  <= nblocks_i;
            chain_q <= iv_i;
        end else if (res_take) begin
            chain_q <= chain_upd;
        end
    end

    // Plaintext, core input and result block registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin : data_regs
        if (!rst_ni) begin
            p_q    <= '0;
            text_q <= '0;
            out_q  <= '0;
        end else begin
            if (a_hs) begin
                p_q <= p_next;
                if (last_beat) text_q <= text_next;
            end
            if (res_take) out_q <= res_out;
        end
    end

    // Beat index and emitted-block counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin : cnt_regs
        if (!rst_ni) begin
            beat_q <= '0;
            blk_q  <= '0;
        end else if (clear_i || start_go) begin
            beat_q <= '0;
            blk_q  <= '0;
        end else if (a_hs || d_hs) begin
            beat_q <= last_beat ? '0 : beat_q + BI_W'(1);
            if (d_hs && last_beat) blk_q <= blk_inc;
        end
    end

    // Per-state core handshake flags and status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin : flag_regs
        if (!rst_ni) begin
            ld_issued_q <= 1'b0;
            got_res_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= zero_done || job_done;
            err_q  <= mode_err;
            if (state_d != state_q) begin
                ld_issued_q <= 1'b0;
                got_res_q   <= 1'b0;
            end else begin
                if (core_ld_o) ld_issued_q <= 1'b1;
                if (res_take || (state_q == ST_FLUSH && core_done_i)) got_res_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: directed + randomized bench with a stand-in cipher core
// and a block-level reference model of the ECB/CBC/CTR chaining rules.
`timescale 1ns/1ps
module tb_aes_mode_engine;

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned BEATS = 128 / DW;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_P   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk_i, rst_ni, clear_i, enable_i, start_i;
    logic [1:0]       mode_i;
    logic [CNT_W-1:0] nblocks_i;
    logic [127:0]     key_i, iv_i;
    logic [DW-1:0]    a_data_i;
    logic             a_valid_i, a_ready_o;
    logic [DW-1:0]    d_data_o;
    logic [DW/8-1:0]  d_strb_o;
    logic             d_valid_o, d_ready_i;
    logic             core_ld_o;
    logic [127:0]     core_key_o, core_text_o;
    logic             core_done_i;
    logic [127:0]     core_text_i;
    logic             busy_o, done_o, err_o;
    logic [CNT_W-1:0] blk_cnt_o;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;
    int done_cnt = 0;
    int stab_bad = 0;
    int lat_min = 1;
    int lat_max = 4;
    logic [127:0] ld_text_q[$];
    logic [127:0] ld_key_q[$];
    logic [127:0] pt_q[$];
    logic [127:0] out_blocks[$];

    aes_mode_engine #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .start_i(start_i), .mode_i(mode_i), .nblocks_i(nblocks_i), .key_i(key_i),
        .iv_i(iv_i), .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .d_data_o(d_data_o), .d_strb_o(d_strb_o), .d_valid_o(d_valid_o),
        .d_ready_i(d_ready_i), .core_ld_o(core_ld_o), .core_key_o(core_key_o),
        .core_text_o(core_text_o), .core_done_i(core_done_i), .core_text_i(core_text_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Stand-in cipher: the known AES-128 answer for the reference vector, a keyed permutation otherwise.
    function automatic logic [127:0] fcore(input logic [127:0] k, input logic [127:0] t);
        if (k == KAT_KEY && t == KAT_P) return KAT_C;
        return {t[62:0], t[127:63]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [127:0] v, input int k);
        return v[127 - k*DW -: DW];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Core responder: latches key/text on each load, answers after a random latency.
    initial begin : core_model
        logic [127:0] ck, ct;
        bit pend;
        int lat;
        core_done_i = 1'b0;
        core_text_i = '0;
        pend = 1'b0;
        lat = 0;
        ck = '0;
        ct = '0;
        forever begin
            @(negedge clk_i);
            #2;
            core_done_i = 1'b0;
            if (pend) begin
                if (lat == 0) begin
                    if (busy_o && (core_text_o !== ct || core_key_o !== ck)) stab_bad++;
                    core_done_i = 1'b1;
                    core_text_i = fcore(ck, ct);
                    pend = 1'b0;
                    done_cnt++;
                end else begin
                    lat--;
                end
            end
            if (core_ld_o === 1'b1) begin
                ld_cnt++;
                if (!pend) begin
                    ct = core_text_o;
                    ck = core_key_o;
                    ld_text_q.push_back(ct);
                    ld_key_q.push_back(ck);
                    pend = 1'b1;
                    lat = $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    task automatic do_start(input logic [1:0] mode, input int nb, input logic [127:0] key,
                            input logic [127:0] iv);
        @(negedge clk_i);
        enable_i  = 1'b1;
        mode_i    = mode;
        nblocks_i = CNT_W'(nb);
        key_i     = key;
        iv_i      = iv;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
    endtask

    task automatic feed_block(input logic [127:0] p);
        int k = 0;
        int w = 0;
        while (k < BEATS && w < 100) begin
            enable_i  = 1'b1;
            a_valid_i = 1'b1;
            a_data_i  = slice(p, k);
            #1;
            if (a_ready_o) k++;
            @(negedge clk_i);
            w++;
        end
        a_valid_i = 1'b0;
        check("feed_done", k, BEATS);
    endtask

    task automatic wait_ld(input int c0);
        int w = 0;
        while (ld_cnt == c0 && w < 60) begin
            @(negedge clk_i);
            w++;
        end
        check("ld_seen", ld_cnt - c0, 1);
    endtask

    // Full job: model predicts core inputs and output blocks, then the DUT is driven and compared.
    task automatic run_job(input logic [1:0] mode, input int nb, input logic [127:0] key,
                           input logic [127:0] iv, input bit rnd, input bit stall);
        logic [127:0] exp_ct[$];
        logic [127:0] exp_core[$];
        logic [127:0] ch, cin, r, got;
        logic [DW-1:0] held;
        int ib, ibt, ob, obt, cyc, stall_n, ld0;
        bit fin, blk_end;
        ch = iv;
        for (int b = 0; b < nb; b++) begin
            case (mode)
                2'd1:    cin = pt_q[b] ^ ch;
                2'd2:    cin = ch;
                default: cin = pt_q[b];
            endcase
            r = fcore(key, cin);
            exp_core.push_back(cin);
            case (mode)
                2'd1: begin exp_ct.push_back(r); ch = r; end
                2'd2: begin exp_ct.push_back(r ^ pt_q[b]); ch[31:0] = ch[31:0] + 32'd1; end
                default: exp_ct.push_back(r);
            endcase
        end
        ld_text_q.delete();
        ld_key_q.delete();
        out_blocks.delete();
        ld0 = ld_cnt;
        do_start(mode, nb, key, iv);
        ib = 0; ibt = 0; ob = 0; obt = 0; cyc = 0; stall_n = 0;
        fin = 1'b0; got = '0; held = '0;
        while (!fin && cyc < 4000) begin
            cyc++;
            enable_i  = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            a_valid_i = (ib < nb) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            a_data_i  = (ib < nb) ? slice(pt_q[ib], ibt) : '0;
            d_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall && ob == 0 && obt == 1 && stall_n < 5) d_ready_i = 1'b0;
            #1;
            if (stall && ob == 0 && obt == 1 && stall_n < 5) begin
                if (stall_n == 0) held = d_data_o;
                else check("stall_data", d_data_o, held);
                check("stall_valid", d_valid_o, 1'b1);
                check("stall_ardy", a_ready_o, 1'b0);
                stall_n++;
            end
            if (!enable_i) begin
                check("frz_ardy", a_ready_o, 1'b0);
                check("frz_dvld", d_valid_o, 1'b0);
                check("frz_ld", core_ld_o, 1'b0);
            end
            if (a_ready_o || d_valid_o) check("no_overlap", a_ready_o & d_valid_o, 1'b0);
            blk_end = 1'b0;
            if (a_ready_o && a_valid_i) begin
                ibt++;
                if (ibt == BEATS) begin ibt = 0; ib++; end
            end
            if (d_valid_o && d_ready_i) begin
                check("strb", d_strb_o, {(DW/8){1'b1}});
                got[127 - obt*DW -: DW] = d_data_o;
                obt++;
                if (obt == BEATS) begin
                    obt = 0;
                    check("blk_data", got, (ob < exp_ct.size()) ? exp_ct[ob] : '0);
                    out_blocks.push_back(got);
                    ob++;
                    blk_end = 1'b1;
                end
            end
            @(posedge clk_i);
            #1;
            if (blk_end) begin
                check("blk_cnt", blk_cnt_o, ob);
                if (ob >= nb) begin
                    check("done_pulse", done_o, 1'b1);
                    check("busy_end", busy_o, 1'b0);
                    fin = 1'b1;
                end else begin
                    check("done_mid", done_o, 1'b0);
                    check("busy_mid", busy_o, 1'b1);
                end
            end
            @(negedge clk_i);
        end
        a_valid_i = 1'b0;
        enable_i  = 1'b1;
        check("job_fin", fin, 1'b1);
        check("ld_count", ld_cnt - ld0, nb);
        check("ld_q_size", ld_text_q.size(), nb);
        check("stab", stab_bad, 0);
        for (int b = 0; b < ld_text_q.size() && b < nb; b++) begin
            check("core_text", ld_text_q[b], exp_core[b]);
            check("core_key", ld_key_q[b], key);
        end
        @(posedge clk_i);
        #1;
        check("done_once", done_o, 1'b0);
        @(negedge clk_i);
    endtask

    initial begin : main
        logic [127:0] k, iv;
        int c0, d0, w;
        rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
        mode_i = '0; nblocks_i = '0; key_i = '0; iv_i = '0;
        a_data_i = '0; a_valid_i = 1'b0; d_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_ardy", a_ready_o, 1'b0);
        check("rst_dvld", d_valid_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_blk", blk_cnt_o, 0);
        check("rst_ld", core_ld_o, 1'b0);
        check("rst_text", core_text_o, 0);
        check("rst_key", core_key_o, 0);
        check("rst_ddata", d_data_o, 0);
        check("rst_strb", d_strb_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reference ECB vector.
        pt_q.delete(); pt_q.push_back(KAT_P);
        run_job(2'd0, 1, KAT_KEY, '0, 1'b0, 1'b0);
        check("kat_ecb", (out_blocks.size() > 0) ? out_blocks[0] : '0, KAT_C);

        // CBC with zero IV on two identical blocks.
        pt_q.delete(); pt_q.push_back(KAT_P); pt_q.push_back(KAT_P);
        run_job(2'd1, 2, KAT_KEY, '0, 1'b0, 1'b0);
        check("cbc_blk1", (out_blocks.size() > 0) ? out_blocks[0] : '0, KAT_C);
        check("cbc_core2", (ld_text_q.size() > 1) ? ld_text_q[1] : '0, KAT_P ^ KAT_C);

        // CTR counter wrap of the low word.
        iv = {rand128() >> 32, 32'hffffffff};
        k  = rand128();
        pt_q.delete(); pt_q.push_back(rand128()); pt_q.push_back(rand128());
        run_job(2'd2, 2, k, iv, 1'b0, 1'b0);
        check("ctr_core2", (ld_text_q.size() > 1) ? ld_text_q[1] : '0, {iv[127:32], 32'h0});

        // Output back-pressure mid-drain.
        pt_q.delete(); pt_q.push_back(rand128()); pt_q.push_back(rand128());
        run_job(2'd0, 2, rand128(), rand128(), 1'b0, 1'b1);

        // Randomized jobs with enable drops and random valid/ready.
        for (int j = 0; j < 8; j++) begin
            int nb;
            logic [1:0] md;
            md = 2'($urandom_range(0, 2));
            nb = $urandom_range(1, 3);
            pt_q.delete();
            for (int b = 0; b < nb; b++) pt_q.push_back(rand128());
            run_job(md, nb, rand128(), rand128(), 1'b1, 1'b0);
        end

        // Zero-length job and reserved mode.
        do_start(2'd0, 0, rand128(), rand128());
        #1;
        check("zero_done", done_o, 1'b1);
        check("zero_busy", busy_o, 1'b0);
        check("zero_ardy", a_ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("zero_done_end", done_o, 1'b0);
        check("zero_busy_end", busy_o, 1'b0);
        check("zero_ardy_end", a_ready_o, 1'b0);
        do_start(2'd3, 2, rand128(), rand128());
        #1;
        check("rsv_err", err_o, 1'b1);
        check("rsv_busy", busy_o, 1'b0);
        check("rsv_done", done_o, 1'b0);
        @(posedge clk_i); #1;
        check("rsv_err_end", err_o, 1'b0);
        check("rsv_busy_end", busy_o, 1'b0);
        @(negedge clk_i);

        // Clear while the core is working: flush, then a fresh job.
        lat_min = 4; lat_max = 6;
        k = rand128();
        do_start(2'd1, 2, k, rand128());
        feed_block(rand128());
        c0 = ld_cnt;
        wait_ld(c0);
        d0 = done_cnt;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        check("flush_busy", busy_o, 1'b1);
        w = 0;
        while (busy_o && w < 50) begin
            check("flush_dvld", d_valid_o, 1'b0);
            check("flush_ardy", a_ready_o, 1'b0);
            @(negedge clk_i); #1;
            w++;
        end
        check("flush_exit", busy_o, 1'b0);
        check("flush_waited", done_cnt, d0 + 1);
        check("flush_blk", blk_cnt_o, 0);
        check("flush_no_done", done_o, 1'b0);
        @(negedge clk_i);
        lat_min = 1; lat_max = 4;
        pt_q.delete(); pt_q.push_back(rand128());
        run_job(2'd2, 1, rand128(), rand128(), 1'b0, 1'b0);

        // Reset mid-job; the late core answer must be ignored.
        lat_min = 3; lat_max = 5;
        do_start(2'd0, 2, rand128(), rand128());
        feed_block(rand128());
        c0 = ld_cnt;
        wait_ld(c0);
        d0 = done_cnt;
        #1;
        rst_ni = 1'b0;
        #1;
        check("mrst_busy", busy_o, 1'b0);
        check("mrst_text", core_text_o, 0);
        check("mrst_key", core_key_o, 0);
        check("mrst_ld", core_ld_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i); #1;
            check("mrst_idle_busy", busy_o, 1'b0);
            check("mrst_idle_dvld", d_valid_o, 1'b0);
        end
        check("mrst_core_fired", done_cnt, d0 + 1);
        lat_min = 1; lat_max = 4;
        pt_q.delete(); pt_q.push_back(rand128()); pt_q.push_back(rand128());
        run_job(2'd1, 2, rand128(), rand128(), 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
